// File: rtl/xbar_demux_router.sv
// Routes one handshaked input stream to NOUT output ports chosen by SEL; 2-entry FIFO per port.
// Latency: a word accepted at edge k is at OUT_DATA/OUT_VALID of its port after edge k (if the port was empty).
// Backpressure: IN_READY drops only when the addressed port FIFO is full; other ports keep flowing.
// Optional build macro XBAR_DEMUX_CNT_EN adds OUT_CNT, an 8-bit wrapping pop counter per port.
module xbar_demux_router #(
    parameter int DW   = 4,
    parameter int SW   = 2,
    parameter int NOUT = 4      // must equal 2**SW
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [DW-1:0]        IN_DATA,
    input  logic [SW-1:0]        SEL,
    output logic [NOUT-1:0]      OUT_VALID,
    input  logic [NOUT-1:0]      OUT_READY,
    output logic [NOUT*DW-1:0]   OUT_DATA
`ifdef XBAR_DEMUX_CNT_EN
    ,
    output logic [NOUT*8-1:0]    OUT_CNT
`endif
);

    // Per-port FIFO state. head_q is a dedicated register so OUT_DATA is a
    // clean flop output and keeps its last value once the port drains.
    logic [DW-1:0] mem_q    [NOUT][2];
    logic [DW-1:0] mem_d    [NOUT][2];
    logic [DW-1:0] head_q   [NOUT];
    logic [DW-1:0] head_d   [NOUT];
    logic          wr_ptr_q [NOUT];
    logic          wr_ptr_d [NOUT];
    logic          rd_ptr_q [NOUT];
    logic          rd_ptr_d [NOUT];
    logic [1:0]    occ_q    [NOUT];
    logic [1:0]    occ_d    [NOUT];
`ifdef XBAR_DEMUX_CNT_EN
    logic [7:0]    cnt_q    [NOUT];
    logic [7:0]    cnt_d    [NOUT];
`endif

    logic accept;

    // Ready depends only on SEL and registered occupancy, never on IN_VALID/OUT_READY.
    always_comb begin
        IN_READY = RST_N && (occ_q[SEL] != 2'd2);
        accept   = IN_VALID && IN_READY;
    end

    // Next-state for every port FIFO: push from the input, pop to the consumer.
    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
`ifdef XBAR_DEMUX_CNT_EN
        cnt_d    = cnt_q;
`endif
        for (int p = 0; p < NOUT; p++) begin
            logic push;
            logic pop;
            push = accept && (SEL == SW'(p));
            pop  = (occ_q[p] != 2'd0) && OUT_READY[p];

            if (push) begin
                mem_d[p][wr_ptr_q[p]] = IN_DATA;
                wr_ptr_d[p]           = ~wr_ptr_q[p];
            end
            if (pop) begin
                rd_ptr_d[p] = ~rd_ptr_q[p];
`ifdef XBAR_DEMUX_CNT_EN
                cnt_d[p]    = cnt_q[p] + 8'd1;
`endif
            end

            case ({push, pop})
                2'b10:   occ_d[p] = occ_q[p] + 2'd1;
                2'b01:   occ_d[p] = occ_q[p] - 2'd1;
                default: occ_d[p] = occ_q[p];
            endcase

            // Head update: second entry moves up when a full FIFO pops; an
            // incoming word becomes head when it lands in an empty slot or
            // replaces a head popping in the same cycle (occ=1).
            if (pop && (occ_q[p] == 2'd2)) begin
                head_d[p] = mem_q[p][~rd_ptr_q[p]];
            end else if (push && ((occ_q[p] == 2'd0) || pop)) begin
                head_d[p] = IN_DATA;
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any in-flight accept/pop.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int p = 0; p < NOUT; p++) begin
                mem_q[p][0] <= '0;
                mem_q[p][1] <= '0;
                head_q[p]   <= '0;
                wr_ptr_q[p] <= 1'b0;
                rd_ptr_q[p] <= 1'b0;
                occ_q[p]    <= 2'd0;
`ifdef XBAR_DEMUX_CNT_EN
                cnt_q[p]    <= 8'd0;
`endif
            end
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
`ifdef XBAR_DEMUX_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Flatten per-port registered state onto the output buses.
    always_comb begin
        OUT_VALID = '0;
        OUT_DATA  = '0;
`ifdef XBAR_DEMUX_CNT_EN
        OUT_CNT   = '0;
`endif
        for (int p = 0; p < NOUT; p++) begin
            OUT_VALID[p]          = (occ_q[p] != 2'd0);
            OUT_DATA[p*DW +: DW]  = head_q[p];
`ifdef XBAR_DEMUX_CNT_EN
            OUT_CNT[p*8 +: 8]     = cnt_q[p];
`endif
        end
    end

endmodule

// File: tb/tb_xbar_demux_router.sv
// Directed bench for xbar_demux_router: reset, sweep, backpressure, push+pop, mid-op reset, pop counter.
// Inputs change 2 time units after a rising edge; outputs are checked in the same window.
// Checks use immediate assertions; the failure count feeds the summary line.
module tb_xbar_demux_router;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
`ifdef XBAR_DEMUX_CNT_EN
    logic [31:0] out_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [1:0] s;
    logic [3:0] d;

    xbar_demux_router #(.DW(4), .SW(2), .NOUT(4)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .SEL       (sel),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data)
`ifdef XBAR_DEMUX_CNT_EN
        ,
        .OUT_CNT   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        in_data   = 4'h5;
        out_ready = 4'h0;

        // 1: reset held for 2 edges with IN_VALID high
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        tick();

        // 2: sweep all {SEL,IN_DATA}, each word alone, consumers always ready
        out_ready = 4'hF;
        for (int v = 0; v < 64; v++) begin
            s        = v[5:4];
            d        = v[3:0];
            sel      = s;
            in_data  = d;
            in_valid = 1'b1;
            #1;
            chk("sweep_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk("sweep_valid", 32'(out_valid), 32'(4'b0001 << s));
            chk("sweep_data", 32'(out_data[s*4 +: 4]), 32'(d));
            tick();
            chk("sweep_drained", 32'(out_valid), 32'd0);
            chk("sweep_data_hold", 32'(out_data[s*4 +: 4]), 32'(d));
        end

        // 3: backpressure on port 2 while port 1 keeps flowing
        out_ready = 4'b1011;
        sel       = 2'd2;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        #1;
        chk("bp_rdy_a", 32'(in_ready), 32'd1);
        tick();
        in_data = 4'hB;
        #1;
        chk("bp_rdy_b", 32'(in_ready), 32'd1);
        tick();
        in_data = 4'hC;
        #1;
        chk("bp_rdy_c_full", 32'(in_ready), 32'd0);
        chk("bp_head_a", 32'(out_data[11:8]), 32'hA);
        tick();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        sel     = 2'd1;
        in_data = 4'h5;
        #1;
        chk("bp_port1_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp_port1_valid", 32'(out_valid), 32'b0110);
        chk("bp_port1_data", 32'(out_data[7:4]), 32'h5);
        sel       = 2'd2;
        in_data   = 4'hC;
        out_ready = 4'hF;
        #1;
        chk("bp_c_blocked", 32'(in_ready), 32'd0);
        tick();
        chk("bp_pop_a_head_b", 32'(out_data[11:8]), 32'hB);
        chk("bp_pop_a_valid", 32'(out_valid), 32'b0100);
        chk("bp_c_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop_b_head_c", 32'(out_data[11:8]), 32'hC);
        chk("bp_pop_b_valid", 32'(out_valid), 32'b0100);
        tick();
        chk("bp_pop_c_empty", 32'(out_valid), 32'd0);

        // 4: simultaneous push and pop on port 3 at occ=1
        out_ready = 4'h0;
        sel       = 2'd3;
        in_data   = 4'h7;
        in_valid  = 1'b1;
        tick();
        chk("sim_head_7", 32'(out_data[15:12]), 32'h7);
        in_data   = 4'h9;
        out_ready = 4'b1000;
        #1;
        chk("sim_rdy", 32'(in_ready), 32'd1);
        tick();
        out_ready = 4'h0;
        chk("sim_valid", 32'(out_valid), 32'b1000);
        chk("sim_head_9", 32'(out_data[15:12]), 32'h9);
        in_data = 4'hE;
        #1;
        chk("sim_occ1_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("sim_occ2_full", 32'(in_ready), 32'd0);
        out_ready = 4'b1000;
        tick();
        chk("sim_head_e", 32'(out_data[15:12]), 32'hE);
        tick();
        chk("sim_empty", 32'(out_valid), 32'd0);

        // 5: reset while ports 0 and 2 are full
        out_ready = 4'h0;
        in_valid  = 1'b1;
        sel = 2'd0; in_data = 4'h1; tick();
        sel = 2'd0; in_data = 4'h2; tick();
        sel = 2'd2; in_data = 4'h3; tick();
        sel = 2'd2; in_data = 4'h4; tick();
        sel = 2'd0;
        #1;
        chk("mid_p0_full", 32'(in_ready), 32'd0);
        chk("mid_valid_pre", 32'(out_valid), 32'b0101);
        rst_n     = 1'b0;
        sel       = 2'd1;
        in_data   = 4'hF;
        out_ready = 4'hF;
        #1;
        chk("mid_rst_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        sel = 2'd0;
        #1;
        chk("mid_p0_rdy", 32'(in_ready), 32'd1);
        in_data   = 4'hD;
        in_valid  = 1'b1;
        out_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        chk("mid_fresh_valid", 32'(out_valid), 32'b0001);
        chk("mid_fresh_data", 32'(out_data[3:0]), 32'hD);
        out_ready = 4'h1;
        tick();
        chk("mid_fresh_pop", 32'(out_valid), 32'd0);

`ifdef XBAR_DEMUX_CNT_EN
        // 6: 300 pops on port 0 wrap its 8-bit counter to 44
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt_rst", out_cnt, 32'd0);
        sel       = 2'd0;
        out_ready = 4'h1;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("cnt_drained", 32'(out_valid), 32'd0);
        chk("cnt_lane0", 32'(out_cnt[7:0]), 32'd44);
        chk("cnt_others", 32'(out_cnt[31:8]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
